// File: rtl/mem_stage.sv
// MEM pipeline stage: accepts instructions from EXE, issues data-SRAM requests in
// the accept cycle, aligns/extends load data and holds it across WB back-pressure.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned access detection).
module mem_stage #(
  parameter int unsigned Xlen = 32,
  parameter int unsigned RfAw = 5
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  // EXE -> MEM
  input  logic                 exe_to_mem_valid_i,
  output logic                 mem_allowin_o,
  input  logic [Xlen-1:0]      exe_pc_i,
  input  logic [Xlen-1:0]      exe_result_i,
  input  logic                 exe_res_from_mem_i,
  input  logic [7:0]           exe_mem_all_i,
  input  logic [Xlen-1:0]      exe_rkd_value_i,
  input  logic [RfAw:0]        exe_rf_all_i,
  // data SRAM
  output logic                 data_sram_en_o,
  output logic [3:0]           data_sram_we_o,
  output logic [Xlen-1:0]      data_sram_addr_o,
  output logic [Xlen-1:0]      data_sram_wdata_o,
  input  logic [Xlen-1:0]      data_sram_rdata_i,
  // MEM -> WB
  input  logic                 wb_allowin_i,
  output logic                 mem_to_wb_valid_o,
  output logic                 mem_valid_o,
  output logic [Xlen-1:0]      mem_pc_o,
  output logic [Xlen-1:0]      mem_final_result_o,
  output logic [RfAw:0]        mem_rf_all_o,
  output logic [RfAw+Xlen+1:0] mem_fwd_all_o,
  output logic                 mem_ale_o
);

  typedef enum logic [1:0] {StIdle, StLive, StHeld} rd_state_e;

  // Decoded memory-op fields
  logic mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w;
  assign {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w} = exe_mem_all_i;

  logic mem_valid_q;
  logic accept;
  logic ale_in;

  assign mem_allowin_o = ~mem_valid_q | wb_allowin_i;
  // Reset gates the accept so no SRAM request leaks out while held in reset.
  assign accept        = exe_to_mem_valid_i & mem_allowin_o & resetn_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign ale_in = ((ld_h | st_h) & exe_result_i[0]) | ((ld_w | st_w) & (|exe_result_i[1:0]));
`else
  assign ale_in = 1'b0;
`endif

  // SRAM request generation: strobes and replicated store data
  always_comb begin
    data_sram_en_o    = accept & (exe_res_from_mem_i | mem_we);
    data_sram_addr_o  = {exe_result_i[Xlen-1:2], 2'b00};
    data_sram_we_o    = 4'b0000;
    data_sram_wdata_o = exe_rkd_value_i;
    if (st_b) begin
      data_sram_wdata_o = {4{exe_rkd_value_i[7:0]}};
    end else if (st_h) begin
      data_sram_wdata_o = {2{exe_rkd_value_i[15:0]}};
    end
    if (accept && mem_we && !ale_in) begin
      if (st_w) begin
        data_sram_we_o = 4'b1111;
      end else if (st_h) begin
        data_sram_we_o = exe_result_i[1] ? 4'b1100 : 4'b0011;
      end else if (st_b) begin
        data_sram_we_o = 4'b0001 << exe_result_i[1:0];
      end
    end
  end

  // Control registers with reset: valid, rf write info, misalign flag
  logic [RfAw:0] rf_all_q;
  logic          ale_q;
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      mem_valid_q <= 1'b0;
      rf_all_q    <= '0;
      ale_q       <= 1'b0;
    end else begin
      if (mem_allowin_o) begin
        mem_valid_q <= exe_to_mem_valid_i;
      end
      if (accept) begin
        // A misaligned load must not write the register file.
        rf_all_q <= {exe_rf_all_i[RfAw] & ~(exe_res_from_mem_i & ale_in), exe_rf_all_i[RfAw-1:0]};
        ale_q    <= ale_in;
      end
    end
  end

  // Datapath registers: load on accept, no reset needed
  logic [Xlen-1:0] pc_q, result_q;
  logic            res_from_mem_q, ld_se_q;
  logic [2:0]      size_q;
  logic [1:0]      addr_lo_q;
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pc_q           <= exe_pc_i;
      result_q       <= exe_result_i;
      res_from_mem_q <= exe_res_from_mem_i;
      ld_se_q        <= ld_se;
      size_q         <= {ld_b, ld_h, ld_w};
      addr_lo_q      <= exe_result_i[1:0];
    end
  end

  // Read-data hold FSM: tracks where the current load's data lives
  rd_state_e       state_q, state_d;
  logic            buf_we;
  logic [Xlen-1:0] rdata_buf_q;
  logic            next_load;
  assign next_load = accept & exe_res_from_mem_i;

  // Next-state logic for the read-data hold FSM
  always_comb begin
    state_d = state_q;
    buf_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (next_load) state_d = StLive;
      end
      StLive: begin
        if (wb_allowin_i) begin
          state_d = next_load ? StLive : StIdle;
        end else begin
          state_d = StHeld;
          buf_we  = 1'b1;
        end
      end
      StHeld: begin
        if (wb_allowin_i) state_d = next_load ? StLive : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register; reset discards any outstanding read
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture SRAM data when WB stalls a live load
  always_ff @(posedge clk_i) begin
    if (buf_we) rdata_buf_q <= data_sram_rdata_i;
  end

  // Load alignment and extension
  logic [Xlen-1:0] raw_rdata, shifted, load_data;
  always_comb begin
    raw_rdata = (state_q == StHeld) ? rdata_buf_q : data_sram_rdata_i;
    shifted   = raw_rdata >> {addr_lo_q, 3'b000};
    unique case (size_q)
      3'b100:  load_data = {{24{ld_se_q & shifted[7]}}, shifted[7:0]};
      3'b010:  load_data = {{16{ld_se_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign mem_valid_o        = mem_valid_q;
  assign mem_to_wb_valid_o  = mem_valid_q;
  assign mem_pc_o           = pc_q;
  assign mem_final_result_o = res_from_mem_q ? load_data : result_q;
  assign mem_rf_all_o       = rf_all_q;
  assign mem_fwd_all_o      = {rf_all_q[RfAw] & mem_valid_q, rf_all_q[RfAw-1:0],
                               mem_final_result_o};
  assign mem_ale_o          = ale_q & mem_valid_q;

endmodule
